// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq -- sequential Y86-64 instruction fetch stage.
//
// Holds the architectural PC and reads one instruction a byte at a time from a
// byte-wide instruction memory over a req/ack handshake. It decodes icode/ifun/
// rA/rB/ValC, computes ValP and reports a status code for the stages downstream.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   imem_req/imem_addr     byte read request and its address (out)
//   imem_ack/imem_rdata    read acknowledge and data byte (in)
//   pc_load/PC_next        next-PC handshake from PC_update (in)
//   PC                     address of the current instruction
//   icode,ifun,rA,rB       decoded instruction fields
//   ValC, ValP             constant word and fall-through PC
//   instr_valid            decode outputs valid and stable
//   stat                   0=AOK 1=HLT 2=ADR 3=INS
//
// Build option: FETCH_TIMEOUT_EN adds an ack watchdog of TIMEOUT_CYCLES wait
// cycles that halts with ADR. Without it, FETCH waits for ack indefinitely.
module pc_fetch_seq #(
   parameter logic [63:0] RESET_PC       = 64'h0,
   parameter int          IMEM_SIZE      = 1024,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [7:0]  imem_rdata,
   input  logic        pc_load,
   input  logic [63:0] PC_next,
   output logic [63:0] PC,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] ValC,
   output logic [63:0] ValP,
   output logic        instr_valid,
   output logic [1:0]  stat
);

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_VALID, ST_HALT} state_t;

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   // Instruction length by icode; 0 marks an illegal icode.
   function automatic logic [3:0] f_len(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       f_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
         4'h7, 4'h8:             f_len = 4'd9;
         4'h3, 4'h4, 4'h5:       f_len = 4'd10;
         default:                f_len = 4'd0;
      endcase
   endfunction

   state_t      r_state, w_state_next;
   logic [63:0] r_pc, r_valc, r_valp;
   logic [3:0]  r_idx, r_len;
   logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
   logic [1:0]  r_stat;

   logic [63:0] w_addr;
   logic        w_addr_ok, w_ack, w_byte0, w_ins_err, w_adr_err, w_last, w_timeout;
   logic [3:0]  w_icode_cur, w_len_cur;

   assign w_addr    = r_pc + {60'd0, r_idx};
   assign w_addr_ok = (w_addr < 64'(IMEM_SIZE));
   assign w_ack     = imem_req & imem_ack;
   assign w_byte0   = (r_idx == 4'd0);
   // On byte 0 the opcode is only on the bus; afterwards it comes from the register.
   assign w_icode_cur = w_byte0 ? imem_rdata[7:4] : r_icode;
   assign w_len_cur   = w_byte0 ? f_len(imem_rdata[7:4]) : r_len;
   assign w_ins_err   = w_ack & w_byte0 & (w_len_cur == 4'd0);
   assign w_adr_err   = (r_state == ST_FETCH) & ~w_addr_ok;
   assign w_last      = w_ack & (w_len_cur != 4'd0) & ((r_idx + 4'd1) == w_len_cur);

`ifdef FETCH_TIMEOUT_EN
   logic [31:0] r_wait;
   // Fires on the TIMEOUT_CYCLES-th consecutive unacknowledged request cycle.
   assign w_timeout = imem_req & ~imem_ack & ((r_wait + 32'd1) == 32'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait <= 32'd0;
      end else if (imem_req & ~imem_ack) begin
         r_wait <= r_wait + 32'd1;
      end else begin
         r_wait <= 32'd0;
      end
   end
`else
   logic w_unused_timeout;
   assign w_timeout        = 1'b0;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  w_state_next = ST_FETCH;
         ST_FETCH: begin
            if (w_adr_err || w_ins_err || w_timeout) begin
               w_state_next = ST_HALT;
            end else if (w_last) begin
               w_state_next = (w_icode_cur == 4'h0) ? ST_HALT : ST_VALID;
            end
         end
         ST_VALID: if (pc_load) w_state_next = ST_FETCH;
         default:  w_state_next = ST_HALT;
      endcase
   end

   // Output logic
   always_comb begin
      imem_req    = (r_state == ST_FETCH) & w_addr_ok;
      imem_addr   = (r_state == ST_FETCH) ? w_addr : 64'd0;
      instr_valid = (r_state == ST_VALID);
   end

   // Datapath: byte capture, status and PC
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_idx   <= 4'd0;
         r_len   <= 4'd0;
         r_icode <= 4'h0;
         r_ifun  <= 4'h0;
         r_ra    <= 4'hF;
         r_rb    <= 4'hF;
         r_valc  <= 64'd0;
         r_valp  <= 64'd0;
         r_stat  <= STAT_AOK;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_adr_err || w_timeout) begin
                  r_stat <= STAT_ADR;
               end else if (w_ack) begin
                  r_idx <= r_idx + 4'd1;
                  if (w_byte0) begin
                     r_icode <= imem_rdata[7:4];
                     r_ifun  <= imem_rdata[3:0];
                     r_ra    <= 4'hF;
                     r_rb    <= 4'hF;
                     r_valc  <= 64'd0;
                     r_valp  <= r_pc + {60'd0, w_len_cur};
                     r_len   <= w_len_cur;
                     if (w_ins_err) r_stat <= STAT_INS;
                  end else if ((r_idx == 4'd1) && ((r_len == 4'd2) || (r_len == 4'd10))) begin
                     r_ra <= imem_rdata[7:4];
                     r_rb <= imem_rdata[3:0];
                  end else begin
                     // Little-endian constant: after eight shifts the first byte is the LSB.
                     r_valc <= {imem_rdata, r_valc[63:8]};
                  end
                  if (w_last) begin
                     r_idx <= 4'd0;
                     if (w_icode_cur == 4'h0) r_stat <= STAT_HLT;
                  end
               end
            end
            ST_VALID: if (pc_load) r_pc <= PC_next;
            default: ;
         endcase
      end
   end

   assign PC    = r_pc;
   assign icode = r_icode;
   assign ifun  = r_ifun;
   assign rA    = r_ra;
   assign rB    = r_rb;
   assign ValC  = r_valc;
   assign ValP  = r_valp;
   assign stat  = r_stat;

endmodule

// File: tb/tb_pc_fetch_seq.sv
module tb_pc_fetch_seq;
   localparam int SIZE = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [7:0]  imem_rdata = 8'h00;
   logic        pc_load = 1'b0;
   logic [63:0] PC_next = 64'd0;
   logic [63:0] PC, ValC, ValP;
   logic [3:0]  icode, ifun, rA, rB;
   logic        instr_valid;
   logic [1:0]  stat;

   always #5 clk = ~clk;

   pc_fetch_seq dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .pc_load(pc_load), .PC_next(PC_next),
      .PC(PC), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .ValC(ValC), .ValP(ValP), .instr_valid(instr_valid), .stat(stat)
   );

   logic [7:0] mem [0:SIZE-1];
   int tests = 0;
   int fails = 0;

   // Memory responder state and request log
   int          delay_mode = 0;
   bit          ack_en = 1'b1;
   bit          spurious_en = 1'b0;
   int          wcnt = 0;
   int          cur_delay = 0;
   int          nreq = 0;
   int          req_cycles = 0;
   logic [63:0] first_addr = 64'd0;
   logic [63:0] max_addr = 64'd0;
   logic [63:0] prev_wait_addr = 64'd0;
   bit          prev_wait = 1'b0;
   bit          addr_unstable = 1'b0;

   function automatic logic [7:0] memrd(input logic [63:0] a);
      logic [9:0] ix;
      ix = a[9:0];
      return (a < 64'(SIZE)) ? mem[ix] : 8'h00;
   endfunction

   function automatic int pick_delay();
      return (delay_mode < 0) ? int'($urandom_range(0, 2)) : delay_mode;
   endfunction

   function automatic int ilen(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       return 1;
         4'h2, 4'h6, 4'hA, 4'hB: return 2;
         4'h7, 4'h8:             return 9;
         4'h3, 4'h4, 4'h5:       return 10;
         default:                return 0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (imem_req) begin
         req_cycles++;
         if (prev_wait && imem_addr !== prev_wait_addr) addr_unstable = 1'b1;
         if (ack_en && wcnt >= cur_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = memrd(imem_addr);
            if (nreq == 0) first_addr = imem_addr;
            if (imem_addr > max_addr) max_addr = imem_addr;
            nreq++;
            wcnt      = 0;
            cur_delay = pick_delay();
            prev_wait = 1'b0;
         end else begin
            imem_ack       = 1'b0;
            imem_rdata     = 8'($urandom);
            prev_wait      = 1'b1;
            prev_wait_addr = imem_addr;
            wcnt++;
         end
      end else begin
         imem_ack   = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
         imem_rdata = 8'($urandom);
         wcnt       = 0;
         prev_wait  = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_delay(input int m);
      delay_mode = m;
      cur_delay  = pick_delay();
   endtask

   task automatic clear_log();
      nreq = 0; req_cycles = 0; max_addr = 64'd0; addr_unstable = 1'b0;
   endtask

   // Reference: fetch outcome of the instruction at pc from the memory image.
   task automatic model(input logic [63:0] pc, output logic [1:0] s, output int n,
                        output logic [3:0] ic, output logic [3:0] fn, output logic [3:0] ra,
                        output logic [3:0] rb, output logic [63:0] vc, output logic [63:0] vp);
      int len;
      logic [7:0] b;
      s = 2'd0; n = 0; ic = 4'h0; fn = 4'h0; ra = 4'hF; rb = 4'hF; vc = 64'd0; vp = 64'd0;
      if (pc >= 64'(SIZE)) begin s = 2'd2; return; end
      b = memrd(pc); n = 1; ic = b[7:4]; fn = b[3:0];
      len = ilen(ic);
      if (len == 0) begin s = 2'd3; return; end
      for (int k = 1; k < len; k++) begin
         if (pc + 64'(k) >= 64'(SIZE)) begin s = 2'd2; n = k; return; end
      end
      n = len;
      if (len == 2 || len == 10) begin
         b = memrd(pc + 64'd1); ra = b[7:4]; rb = b[3:0];
      end
      if (len >= 9) begin
         for (int k = 0; k < 8; k++) vc = vc | (64'(memrd(pc + 64'(len - 8 + k))) << (8 * k));
      end
      vp = pc + 64'(len);
      s  = (ic == 4'h0) ? 2'd1 : 2'd0;
   endtask

   task automatic check_instr(input string tag, input logic [63:0] pc);
      logic [1:0] s; int n; logic [3:0] ic, fn, ra, rb; logic [63:0] vc, vp;
      model(pc, s, n, ic, fn, ra, rb, vc, vp);
      $display("[TB] %s pc=%0h icode=%0h ifun=%0h rA=%0h rB=%0h ValC=%0h ValP=%0h stat=%0d reqs=%0d",
               tag, PC, icode, ifun, rA, rB, ValC, ValP, stat, nreq);
      chk({tag, ".stat"}, 64'(stat), 64'(s));
      chk({tag, ".nreq"}, 64'(nreq), 64'(n));
      chk({tag, ".valid"}, 64'(instr_valid), 64'(s == 2'd0));
      chk({tag, ".pc"}, PC, pc);
      if (s == 2'd0 || s == 2'd1) begin
         chk({tag, ".icode"}, 64'(icode), 64'(ic));
         chk({tag, ".ifun"}, 64'(ifun), 64'(fn));
         chk({tag, ".rA"}, 64'(rA), 64'(ra));
         chk({tag, ".rB"}, 64'(rB), 64'(rb));
         chk({tag, ".ValC"}, ValC, vc);
         chk({tag, ".ValP"}, ValP, vp);
      end
   endtask

   // Wait until the fetch settles (valid or halted); returns cycle count.
   task automatic wait_settle(output int cyc, input bit noise);
      bit done;
      cyc = 0; done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk); #1;
         cyc++;
         pc_load = 1'b0;
         if (instr_valid || stat != 2'd0) done = 1'b1;
         else if (noise) begin
            pc_load = 1'($urandom_range(0, 1));
            PC_next = {$urandom, $urandom};
         end
      end
      pc_load = 1'b0;
      chk("settle_budget", 64'(done), 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
   endtask

   task automatic load_pc(input logic [63:0] a);
      clear_log();
      pc_load = 1'b1; PC_next = a;
      @(posedge clk); #1;
      pc_load = 1'b0; PC_next = {$urandom, $urandom};
   endtask

   initial begin
      int cyc;
      logic [63:0] pc;
      logic [3:0] ic;
      int len;
      for (int i = 0; i < SIZE; i++) mem[i] = 8'h10;

      // T1: reset state, irmovq $10,%rsp at 0 with zero-wait ack
      mem[0] = 8'h30; mem[1] = 8'hF4; mem[2] = 8'h0A;
      for (int i = 3; i < 10; i++) mem[i] = 8'h00;
      set_delay(0);
      do_reset();
      chk("rst.req", 64'(imem_req), 64'd0);
      chk("rst.addr", imem_addr, 64'd0);
      chk("rst.pc", PC, 64'd0);
      chk("rst.icode", 64'(icode), 64'd0);
      chk("rst.rA", 64'(rA), 64'hF);
      chk("rst.rB", 64'(rB), 64'hF);
      chk("rst.ValC", ValC, 64'd0);
      chk("rst.ValP", ValP, 64'd0);
      chk("rst.valid", 64'(instr_valid), 64'd0);
      chk("rst.stat", 64'(stat), 64'd0);
      reset = 1'b0;
      clear_log();
      wait_settle(cyc, 1'b0);
      chk("t1.latency", 64'(cyc), 64'd11);
      check_instr("t1", 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t1.hold_valid", 64'(instr_valid), 64'd1);
      chk("t1.hold_ValC", ValC, 64'd10);

      // T2: jmp 0x100 at 0x40
      mem[64] = 8'h70; mem[65] = 8'h00; mem[66] = 8'h01;
      for (int i = 67; i < 73; i++) mem[i] = 8'h00;
      load_pc(64'h40);
      wait_settle(cyc, 1'b0);
      chk("t2.latency", 64'(cyc), 64'd9);
      chk("t2.first_addr", first_addr, 64'h40);
      chk("t2.last_addr", max_addr, 64'h48);
      check_instr("t2", 64'h40);

      // Randomized legal instructions, random wait states, spurious acks,
      // and pc_load noise while fetching.
      spurious_en = 1'b1;
      set_delay(-1);
      for (int t = 0; t < 30; t++) begin
         ic  = 4'($urandom_range(1, 11));
         len = ilen(ic);
         pc  = 64'($urandom_range(0, SIZE - len));
         mem[pc[9:0]] = {ic, 4'($urandom)};
         for (int k = 1; k < len; k++) mem[pc[9:0] + 10'(k)] = 8'($urandom);
         load_pc(pc);
         wait_settle(cyc, 1'b1);
         chk("rnd.addr_stable", 64'(addr_unstable), 64'd0);
         check_instr("rnd", pc);
      end
      spurious_en = 1'b0;
      set_delay(0);

      // T3: halt at 0, then pc_load pulses must be ignored
      mem[0] = 8'h00;
      do_reset();
      reset = 1'b0;
      clear_log();
      wait_settle(cyc, 1'b0);
      check_instr("t3", 64'd0);
      for (int i = 0; i < 20; i++) begin
         pc_load = i[0]; PC_next = 64'h40;
         @(posedge clk); #1;
      end
      pc_load = 1'b0;
      chk("t3.nreq_after", 64'(nreq), 64'd1);
      chk("t3.stat_after", 64'(stat), 64'd1);
      chk("t3.pc_after", PC, 64'd0);
      chk("t3.req_after", 64'(imem_req), 64'd0);
      chk("t3.valid_after", 64'(instr_valid), 64'd0);

      // T4: illegal opcode, then a 10-byte instruction at the last byte
      mem[0] = 8'hC0;
      do_reset();
      reset = 1'b0;
      clear_log();
      wait_settle(cyc, 1'b0);
      check_instr("t4.ins", 64'd0);
      mem[0] = 8'h10;
      do_reset();
      reset = 1'b0;
      clear_log();
      wait_settle(cyc, 1'b0);
      check_instr("t4.nop", 64'd0);
      mem[SIZE-1] = 8'h30;
      load_pc(64'(SIZE - 1));
      wait_settle(cyc, 1'b0);
      check_instr("t4.adr", 64'(SIZE - 1));
      chk("t4.max_addr", max_addr, 64'(SIZE - 1));

      // T5: 3 wait cycles per byte on addq, then reset mid-fetch
      mem[0] = 8'h60; mem[1] = 8'h12;
      set_delay(3);
      do_reset();
      reset = 1'b0;
      clear_log();
      wait_settle(cyc, 1'b0);
      check_instr("t5", 64'd0);
      chk("t5.addr_stable", 64'(addr_unstable), 64'd0);
      chk("t5.req_cycles", 64'(req_cycles), 64'd8);
      do_reset();
      reset = 1'b0;
      clear_log();
      for (int i = 0; i < 20 && nreq < 1; i++) begin
         @(posedge clk); #1;
      end
      chk("t5.byte0_seen", 64'(nreq), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t5.mid_req", 64'(imem_req), 64'd0);
      chk("t5.mid_pc", PC, 64'd0);
      chk("t5.mid_rA", 64'(rA), 64'hF);
      reset = 1'b0;
      clear_log();
      wait_settle(cyc, 1'b0);
      chk("t5.refetch_addr", first_addr, 64'd0);
      check_instr("t5.refetch", 64'd0);
      set_delay(0);

`ifdef FETCH_TIMEOUT_EN
      // T6: ack withheld -> 16 wait cycles then ADR
      mem[16] = 8'h10;
      ack_en = 1'b0;
      load_pc(64'd16);
      wait_settle(cyc, 1'b0);
      chk("t6.stat", 64'(stat), 64'd2);
      chk("t6.wait_cycles", 64'(req_cycles), 64'd16);
      chk("t6.req", 64'(imem_req), 64'd0);
      chk("t6.nreq", 64'(nreq), 64'd0);
      ack_en = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
